// File: rtl/cypher_ctrl.sv
// Sequencer for the one-time-pad cypher datapath: accepts a plaintext, pulses the
// datapath load, waits out the block/crypt latency, captures the ciphertext and manages pad slots.
module cypher_ctrl #(
  parameter int MSG_SIZE  = 32,
  parameter int KEY_SIZE  = 8,
  parameter int CRYPT_LAT = 1,
  parameter int KEY_SLOTS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [MSG_SIZE-1:0]          req_msg,
  output logic                         dp_load,
  output logic [MSG_SIZE-1:0]          dp_msg,
  output logic [$clog2(KEY_SLOTS)-1:0] key_idx,
  input  logic [MSG_SIZE-1:0]          dp_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [MSG_SIZE-1:0]          rsp_data,
  output logic [$clog2(KEY_SLOTS)-1:0] rsp_key_idx,
  output logic                         pad_exhausted,
  input  logic                         pad_rearm
);

  localparam int N_BLOCKS = MSG_SIZE / KEY_SIZE;
  localparam int RUN_LEN  = N_BLOCKS + CRYPT_LAT;
  localparam int KW       = $clog2(KEY_SLOTS);
  localparam int CW       = $clog2(RUN_LEN + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(RUN_LEN - 1);
  localparam logic [KW-1:0] SLOT_LAST = KW'(KEY_SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept, rearm, capture, complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    rearm    = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        // Rearm takes priority; a request presented alongside it is taken next cycle.
        if (pad_rearm) begin
          rearm = 1'b1;
        end else if (req_valid && !pad_exhausted) begin
          accept   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = RUN;
      RUN: begin
        if (cnt == CNT_LAST) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      dp_msg        <= '0;
      key_idx       <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_key_idx   <= '0;
      pad_exhausted <= 1'b0;
    end else begin
      if (accept) dp_msg <= req_msg;

      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;

      if (capture) begin
        rsp_data    <= dp_out;
        rsp_key_idx <= key_idx;
        rsp_valid   <= 1'b1;
      end

      if (rearm) begin
        key_idx       <= '0;
        pad_exhausted <= 1'b0;
      end else if (complete) begin
        rsp_valid <= 1'b0;
        if (key_idx == SLOT_LAST) begin
          key_idx       <= '0;
          pad_exhausted <= 1'b1;
        end else begin
          key_idx <= key_idx + 1'b1;
        end
      end
    end
  end

  assign req_ready = (state == IDLE) && !pad_exhausted;
  assign dp_load   = (state == LOAD);

endmodule

// File: tb/tb_cypher_ctrl.sv
// Directed bench for cypher_ctrl with a small behavioural cypher datapath
// (rotate-and-XOR one key byte per cycle, result visible for one cycle only).
module tb_cypher_ctrl;

  localparam int MSG_SIZE  = 32;
  localparam int KEY_SIZE  = 8;
  localparam int CRYPT_LAT = 1;
  localparam int KEY_SLOTS = 4;
  localparam int N_BLOCKS  = MSG_SIZE / KEY_SIZE;
  localparam logic [7:0] KEY = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_msg = '0;
  logic        dp_load;
  logic [31:0] dp_msg;
  logic [1:0]  key_idx;
  logic [31:0] dp_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_key_idx;
  logic        pad_exhausted;
  logic        pad_rearm = 1'b0;

  int total = 0;
  int bad   = 0;

  cypher_ctrl #(
    .MSG_SIZE (MSG_SIZE),
    .KEY_SIZE (KEY_SIZE),
    .CRYPT_LAT(CRYPT_LAT),
    .KEY_SLOTS(KEY_SLOTS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_msg      (req_msg),
    .dp_load      (dp_load),
    .dp_msg       (dp_msg),
    .key_idx      (key_idx),
    .dp_out       (dp_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_key_idx  (rsp_key_idx),
    .pad_exhausted(pad_exhausted),
    .pad_rearm    (pad_rearm)
  );

  always #5 clk = ~clk;

  // Datapath model: load on dp_load, one block per cycle, word valid only when k == N_BLOCKS.
  logic [31:0] sr = '0;
  int          k  = N_BLOCKS + 1;
  always @(posedge clk) begin
    if (dp_load) begin
      sr <= dp_msg;
      k  <= 0;
    end else if (k < N_BLOCKS) begin
      sr <= {sr[23:0], sr[31:24] ^ KEY};
      k  <= k + 1;
    end else if (k == N_BLOCKS) begin
      k <= k + 1;
    end
  end
  assign dp_out = (k == N_BLOCKS) ? sr : 32'h0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts right after the accept edge; runs the transaction to completion.
  task automatic finish_msg(input logic [31:0] exp_data, input logic [1:0] exp_key,
                            input int stall, input logic [1:0] exp_next_key,
                            input logic exp_exh);
    int n;
    req_valid = 1'b0;
    check("dp_load_high", dp_load, 1'b1);
    check("req_ready_load", req_ready, 1'b0);
    tick();
    check("dp_load_low", dp_load, 1'b0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("rsp_latency", n, 6);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_key_idx", rsp_key_idx, exp_key);
    check("key_idx_stable", key_idx, exp_key);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_data", rsp_data, exp_data);
      check("stall_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_clr", rsp_valid, 1'b0);
    check("key_idx_next", key_idx, exp_next_key);
    check("pad_exhausted", pad_exhausted, exp_exh);
    check("req_ready_after", req_ready, !exp_exh);
  endtask

  task automatic send(input logic [31:0] msg, input logic [31:0] exp_data,
                      input logic [1:0] exp_key, input int stall,
                      input logic [1:0] exp_next_key, input logic exp_exh);
    int n;
    req_valid = 1'b1;
    req_msg   = msg;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_timeout", n < 20, 1'b1);
    tick();
    finish_msg(exp_data, exp_key, stall, exp_next_key, exp_exh);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_dp_load", dp_load, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_pad_exh", pad_exhausted, 1'b0);
    check("rst_dp_msg", dp_msg, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_key_idx", key_idx, 2'd0);
    check("post_rst_rsp_data", rsp_data, 32'h0);

    // First message with a 10-cycle response stall
    send(32'hDEADBEEF, 32'h21524110, 2'd0, 10, 2'd1, 1'b0);
    check("dp_msg_retained", dp_msg, 32'hDEADBEEF);

    // Rearm and request together: rearm applied, request taken one cycle later
    req_valid = 1'b1;
    req_msg   = 32'h12345678;
    pad_rearm = 1'b1;
    tick();
    pad_rearm = 1'b0;
    check("rearm_no_accept", dp_load, 1'b0);
    check("rearm_key_idx", key_idx, 2'd0);
    check("rearm_req_ready", req_ready, 1'b1);
    tick();
    finish_msg(32'hEDCBA987, 2'd0, 0, 2'd1, 1'b0);

    // Remaining slots back to back, ending exhausted
    send(32'hA5A5A5A5, 32'h5A5A5A5A, 2'd1, 0, 2'd2, 1'b0);
    send(32'h0F0F00FF, 32'hF0F0FF00, 2'd2, 0, 2'd3, 1'b0);
    send(32'hCAFEF00D, 32'h35010FF2, 2'd3, 0, 2'd0, 1'b1);

    // Fifth request is held off while exhausted
    req_valid = 1'b1;
    req_msg   = 32'h00000000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("exh_no_load", dp_load, 1'b0);
      check("exh_req_ready", req_ready, 1'b0);
    end

    // Rearm in IDLE while exhausted; the held request then goes through on slot 0
    pad_rearm = 1'b1;
    tick();
    pad_rearm = 1'b0;
    check("rearm2_exh", pad_exhausted, 1'b0);
    check("rearm2_key_idx", key_idx, 2'd0);
    check("rearm2_req_ready", req_ready, 1'b1);
    check("rearm2_no_load", dp_load, 1'b0);
    tick();
    finish_msg(32'hFFFFFFFF, 2'd0, 0, 2'd1, 1'b0);

    // Asynchronous reset during RUN at counter 2
    req_valid = 1'b1;
    req_msg   = 32'h13579BDF;
    tick();
    req_valid = 1'b0;
    check("abort_load", dp_load, 1'b1);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 1'b1);
    check("arst_dp_load", dp_load, 1'b0);
    check("arst_dp_msg", dp_msg, 32'h0);
    check("arst_key_idx", key_idx, 2'd0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_rsp_data", rsp_data, 32'h0);
    check("arst_rsp_key", rsp_key_idx, 2'd0);
    check("arst_exh", pad_exhausted, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    send(32'h2468ACE0, 32'hDB97531F, 2'd0, 0, 2'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
